// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative signed/unsigned multiply/divide with HI/LO registers
// Rev 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_srcA,
    input  logic [WIDTH-1:0] i_srcB,
    input  logic             i_cancel,
    input  logic             i_mtEn,
    input  logic             i_mtSel,
    input  logic [WIDTH-1:0] i_mtData,
    output logic             o_busy,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_ready;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_dsub;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remv;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_sa     = i_op[0] & i_srcA[WIDTH-1];
    assign w_sb     = i_op[0] & i_srcB[WIDTH-1];
    assign w_magA   = w_sa ? -i_srcA : i_srcA;
    assign w_magB   = w_sb ? -i_srcB : i_srcB;

    // Multiply: lower half of r_acc holds the multiplier, shifted out LSB first.
    assign w_madd   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

    // Divide: lower half of r_acc holds the dividend and collects quotient bits.
    // The partial remainder is WIDTH+1 bits; the subtraction result always fits WIDTH.
    assign w_shift  = {r_rem, r_acc[WIDTH-1]};
    assign w_ge     = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_opb);
    assign w_dsub   = w_shift[WIDTH-1:0] - r_opb;

    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quo    = r_dz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_remv   = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN: begin
                if (i_cancel)            w_next = S_IDLE;
                else if (r_cnt == '0)    w_next = S_FIX;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_opb   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div   <= i_op[1];
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        r_dz    <= i_op[1] && (i_srcB == '0);
                        r_ready <= 1'b0;
                        r_cnt   <= C_CNT_INIT;
                        r_acc   <= {{WIDTH{1'b0}}, w_magA};
                        r_rem   <= '0;
                        r_opb   <= w_magB;
                    end else if (i_mtEn) begin
                        if (i_mtSel) r_hi <= i_mtData;
                        else         r_lo <= i_mtData;
                    end
                end
                S_RUN: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    if (r_div) begin
                        r_rem <= w_ge ? w_dsub : w_shift[WIDTH-1:0];
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= {w_madd, r_acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!i_cancel) begin
                        r_ready <= 1'b1;
                        if (r_div) begin
                            r_hi <= w_remv;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_ready = r_ready;
    assign o_hi    = r_hi;
    assign o_lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit (WIDTH 32 and 8)
// Rev 1.0
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0, cancel = 1'b0, mt_en = 1'b0, mt_sel = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, mt_data = '0;
    logic        busy, ready;
    logic [31:0] hi, lo;

    logic        s8_start = 1'b0, s8_cancel = 1'b0, s8_mt_en = 1'b0, s8_mt_sel = 1'b0;
    logic [1:0]  s8_op = 2'b00;
    logic [7:0]  s8_a = '0, s8_b = '0, s8_mt_data = '0;
    logic        s8_busy, s8_ready;
    logic [7:0]  s8_hi, s8_lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op), .i_srcA(a), .i_srcB(b),
        .i_cancel(cancel), .i_mtEn(mt_en), .i_mtSel(mt_sel), .i_mtData(mt_data),
        .o_busy(busy), .o_ready(ready), .o_hi(hi), .o_lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(s8_start), .i_op(s8_op), .i_srcA(s8_a), .i_srcB(s8_b),
        .i_cancel(s8_cancel), .i_mtEn(s8_mt_en), .i_mtSel(s8_mt_sel), .i_mtData(s8_mt_data),
        .o_busy(s8_busy), .o_ready(s8_ready), .o_hi(s8_hi), .o_lo(s8_lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one 32-bit op from a negedge in IDLE and checks the full latency profile.
    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] rh, input logic [31:0] rl);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_c1"}, {63'd0, busy}, 64'd1);
        check({tag, ".ready_c1"}, {63'd0, ready}, 64'd0);
        repeat (32) @(negedge clk);
        check({tag, ".busy_c33"}, {63'd0, busy}, 64'd1);
        check({tag, ".hilo_c33"}, {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        exp_hi = rh;
        exp_lo = rl;
        check({tag, ".ready_c34"}, {62'd0, busy, ready}, 64'd1);
        check({tag, ".hilo"}, {hi, lo}, {rh, rl});
    endtask

    logic [1:0]  v_op [0:10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b10};
    logic [31:0] v_a  [0:10] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h1234, 32'h80000000,
                                 32'hFFFFFFF9, 32'h12345678, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] v_b  [0:10] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF,
                                 32'd0, 32'h10, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h10};
    logic [31:0] v_hi [0:10] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h1234, 32'd0,
                                 32'hFFFFFFF9, 32'd1, 32'd1, 32'd0, 32'hF};
    logic [31:0] v_lo [0:10] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF, 32'h80000000,
                                 32'hFFFFFFFF, 32'h23456780, 32'hFFFFFFFD, 32'd1, 32'h0FFFFFFF};

    initial begin
        repeat (2) @(negedge clk);
        check("rst.flags32", {62'd0, busy, ready}, 64'd0);
        check("rst.hilo32", {hi, lo}, 64'd0);
        check("rst.all8", {46'd0, s8_busy, s8_ready, s8_hi, s8_lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each op starts in the first cycle ready is high.
        for (int i = 0; i <= 10; i++) begin
            run32($sformatf("vec%0d", i), v_op[i], v_a[i], v_b[i], v_hi[i], v_lo[i]);
        end

        mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'hA5A5A5A5;
        @(negedge clk);
        mt_en = 1'b0;
        exp_lo = 32'hA5A5A5A5;
        check("mtlo.hilo", {hi, lo}, {exp_hi, exp_lo});
        check("mtlo.ready", {63'd0, ready}, 64'd1);
        mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'h5A5A5A5A;
        @(negedge clk);
        mt_en = 1'b0;
        exp_hi = 32'h5A5A5A5A;
        check("mthi.hilo", {hi, lo}, {exp_hi, exp_lo});

        // Start, re-start and mtEn while busy (ignored), then cancel at cycle 10.
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("cxl.busy_c1", {63'd0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h0;
        @(negedge clk);
        start = 1'b0; mt_en = 1'b0;
        check("cxl.hilo_c6", {hi, lo}, {exp_hi, exp_lo});
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cxl.flags_c11", {62'd0, busy, ready}, 64'd0);
        check("cxl.hilo_c11", {hi, lo}, {exp_hi, exp_lo});
        repeat (40) @(negedge clk);
        check("cxl.flags_late", {62'd0, busy, ready}, 64'd0);
        check("cxl.hilo_late", {hi, lo}, {exp_hi, exp_lo});

        run32("post_cxl", 2'b00, 32'h00010000, 32'h00030005, 32'h3, 32'h00050000);

        // WIDTH=8: start and mtEn together in IDLE, start wins.
        s8_start = 1'b1; s8_op = 2'b01; s8_a = 8'h80; s8_b = 8'h80;
        s8_mt_en = 1'b1; s8_mt_sel = 1'b0; s8_mt_data = 8'h55;
        @(negedge clk);
        s8_start = 1'b0; s8_mt_en = 1'b0;
        check("w8.lo_c1", {56'd0, s8_lo}, 64'd0);
        check("w8.busy_c1", {63'd0, s8_busy}, 64'd1);
        repeat (8) @(negedge clk);
        check("w8.flags_c9", {62'd0, s8_busy, s8_ready}, 64'd2);
        @(negedge clk);
        check("w8.flags_c10", {62'd0, s8_busy, s8_ready}, 64'd1);
        check("w8.hilo", {48'd0, s8_hi, s8_lo}, 64'h4000);
        s8_mt_en = 1'b1; s8_mt_sel = 1'b1; s8_mt_data = 8'h77;
        @(negedge clk);
        s8_mt_en = 1'b0;
        check("w8.mthi", {47'd0, s8_ready, s8_hi, s8_lo}, 64'h17700);

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.flags32", {62'd0, busy, ready}, 64'd0);
        check("arst.hilo32", {hi, lo}, 64'd0);
        check("arst.all8", {46'd0, s8_busy, s8_ready, s8_hi, s8_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        run32("post_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, the next generation of the pipeline's execute-stage multiplier. It accepts signed or unsigned multiply and divide operations and computes them with a radix-2 shift-add or restoring-divide datapath over WIDTH iterations. It raises a level `ready` consumed by the hazard detector and exposes HI/LO for mfhi/mflo selection in the execute result mux. It also supports direct HI/LO writes (mthi/mtlo) and cancellation by pipeline flush.

## Interface
- WIDTH, 32, operand and HI/LO width; legal values are even and ≥ 4
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  request an operation; sampled only in IDLE
- op  in  2  00 multu, 01 mult, 10 divu, 11 div
- srcA  in  WIDTH  multiplicand / dividend
- srcB  in  WIDTH  multiplier / divisor
- cancel  in  1  abort an in-flight operation (driven by FlushE)
- mtEn  in  1  write HI or LO directly
- mtSel  in  1  0 selects LO, 1 selects HI
- mtData  in  WIDTH  data for mtEn
- busy  out  1  operation in flight
- ready  out  1  level; result valid in hi/lo
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start:
  - latch op.
  - Compute operand magnitudes: absolute value when op[0]=1 and the MSB is set, otherwise raw.
  - Record negate flags:
    - product/quotient sign = sign(A) XOR sign(B).
    - remainder sign = sign(A).
  - Load iteration counter = WIDTH−1 and clear ready; go to RUN.
- RUN, multiply:
  - 2W-bit accumulator.
  - Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half, then shift right 1.
- RUN, divide:
  - Restoring division; each cycle yields one quotient bit, MSB first.
  - The partial remainder is W+1 bits.
- RUN exits to FIX when the counter reaches 0 (WIDTH RUN cycles). The counter decrements in RUN only.
- FIX:
  - Apply two's-complement negation to the 2W product, or separately to the quotient and the remainder, per the flags.
  - Write hi/lo: product upper→hi, lower→lo; quotient→lo, remainder→hi.
  - Set ready and go to IDLE.
- Divide by zero (srcB=0 at accept, either signedness):
  - Full latency is still taken.
  - Result: lo = all ones, hi = srcA exactly as presented.
- Signed overflow (most-negative ÷ −1): lo = most-negative, hi = 0. This falls out of the magnitude datapath; no special case.
- start while busy: ignored.
- mtEn while busy: ignored.
- start and mtEn in the same IDLE cycle: start wins, mtEn dropped.
- mtEn in IDLE: the selected register updates at the next edge; ready unchanged.
- cancel in RUN or FIX: return to IDLE next edge; busy=0, ready=0, hi/lo keep pre-operation values. cancel in IDLE has no effect.

## Timing
- Reset values: state IDLE, busy=0, ready=0, hi=0, lo=0, counter=0.
- Start sampled at edge T:
  - busy=1 from cycle T+1 through T+WIDTH+1.
  - hi/lo written at edge T+WIDTH+1.
  - ready=1 and busy=0 from cycle T+WIDTH+2.
  - Latency is WIDTH+2 cycles, the same for every op and every operand.
- ready stays high until the next accepted start (cleared at that edge) or reset.
- hi/lo change only in FIX, on an accepted mtEn, or on reset. They are never partially updated mid-operation.
- Back-to-back operation: start may be asserted in the first cycle ready=1.
- Async reset mid-operation: all outputs go to reset values without waiting for a clock edge.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=32, multu 0xFFFFFFFF×0xFFFFFFFF, start at edge 0 → busy cycles 1–33; hi=0xFFFFFFFE, lo=0x00000001, ready=1 at cycle 34.
- mult −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. div −7÷2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7÷2 → lo=3, hi=1.
- divu 0x1234÷0 → lo=0xFFFFFFFF, hi=0x00001234 after 34 cycles. div 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0.
- Sequence:
  - mtlo 0xA5A5A5A5, then mthi 0x5A5A5A5A → hi/lo hold those values.
  - Start mult; pulse start again at cycle 5 → ignored.
  - cancel at cycle 10 → busy=0 at cycle 11, ready=0, hi/lo unchanged.
- Async reset: start divu; drive reset=0 mid-cycle 20 → busy, ready, hi, lo all 0 immediately. Release and start again → correct result at full latency.
- WIDTH=8, mult 0x80×0x80 → hi=0x40, lo=0x00, ready at cycle 10. Same cycle start+mtEn in IDLE → mt dropped.
